// File: rtl/modular_double_seq_pkg.sv
// Shared constants, state type and input-reduction helper for the modular doubler.
// Included by every other file of the modular_double_seq slice.
package kd_params_pkg;

  localparam int DATA_W = 24;
  localparam int K_W    = 5;
  localparam int LANE_K = 12;
  localparam int LANE_D = 23;

  localparam logic [11:0] Q_K = 12'd3329;
  localparam logic [22:0] Q_D = 23'd8380417;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Brings each lane from [0, 2q) into [0, q) with a single conditional subtract.
  function automatic logic [23:0] reduceWord(input logic [23:0] x, input logic dil);
    logic [11:0] hi;
    logic [11:0] lo;
    logic [22:0] d;
    hi = x[23:12];
    lo = x[11:0];
    d  = x[22:0];
    if (dil) begin
      return {1'b0, (d >= Q_D) ? (d - Q_D) : d};
    end
    return {(hi >= Q_K) ? (hi - Q_K) : hi, (lo >= Q_K) ? (lo - Q_K) : lo};
  endfunction

endpackage

// File: rtl/modular_double_seq_if.sv
// Handshake bundle of the modular doubler: input word/count/mode and result side.
interface modular_double_seq_if;
  import kd_params_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x_in;
  logic [K_W-1:0]    k_in;
  logic              KD_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y_out;
  logic              busy;

  modport master (
    output in_valid, x_in, k_in, KD_mode, out_ready,
    input  in_ready, out_valid, y_out, busy
  );

  modport slave (
    input  in_valid, x_in, k_in, KD_mode, out_ready,
    output in_ready, out_valid, y_out, busy
  );

endinterface

// File: rtl/modular_double_seq_lane.sv
// One lane of "double and conditionally subtract q"; purely combinational.
module modular_double_lane #(
  parameter int unsigned      W = 12,
  parameter logic [W-1:0]     Q = 12'd3329
) (
  input  logic [W-1:0] d_i,
  output logic [W-1:0] y_o
);

  logic [W:0] t;

  assign t = {d_i, 1'b0};
  // With d < q the result is below q, so the wrap of the W-bit subtract is harmless.
  assign y_o = (t >= {1'b0, Q}) ? (t[W-1:0] - Q) : t[W-1:0];

endmodule

// File: rtl/modular_double_seq.sv
// Sequential modular doubler: y = x * 2^k mod q, Kyber (2x12-bit) or Dilithium (1x23-bit).
// Define MODULAR_DOUBLE_DUAL_STEP_EN to perform two doublings per RUN cycle.
module modular_double_seq
  import kd_params_pkg::*;
(
  input logic                clk,
  input logic                rst,
  modular_double_seq_if.slave bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [K_W-1:0]    cnt_q, cnt_d;
  logic              mode_q, mode_d;

  logic [DATA_W-1:0] stepOne;
  logic [11:0]       kyHOne, kyLOne;
  logic [22:0]       dilOne;

  modular_double_lane #(.W(LANE_K), .Q(Q_K)) uKyH1 (.d_i(data_q[23:12]), .y_o(kyHOne));
  modular_double_lane #(.W(LANE_K), .Q(Q_K)) uKyL1 (.d_i(data_q[11:0]),  .y_o(kyLOne));
  modular_double_lane #(.W(LANE_D), .Q(Q_D)) uDil1 (.d_i(data_q[22:0]),  .y_o(dilOne));

  assign stepOne = mode_q ? {1'b0, dilOne} : {kyHOne, kyLOne};

`ifdef MODULAR_DOUBLE_DUAL_STEP_EN
  logic [DATA_W-1:0] stepTwo;
  logic [11:0]       kyHTwo, kyLTwo;
  logic [22:0]       dilTwo;

  modular_double_lane #(.W(LANE_K), .Q(Q_K)) uKyH2 (.d_i(stepOne[23:12]), .y_o(kyHTwo));
  modular_double_lane #(.W(LANE_K), .Q(Q_K)) uKyL2 (.d_i(stepOne[11:0]),  .y_o(kyLTwo));
  modular_double_lane #(.W(LANE_D), .Q(Q_D)) uDil2 (.d_i(stepOne[22:0]),  .y_o(dilTwo));

  assign stepTwo = mode_q ? {1'b0, dilTwo} : {kyHTwo, kyLTwo};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = reduceWord(bus.x_in, bus.KD_mode);
          cnt_d   = bus.k_in;
          mode_d  = bus.KD_mode;
          state_d = (bus.k_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
`ifdef MODULAR_DOUBLE_DUAL_STEP_EN
        // An odd remaining count finishes with a lone single step.
        if (cnt_q == 5'd1) begin
          data_d = stepOne;
          cnt_d  = '0;
        end else begin
          data_d = stepTwo;
          cnt_d  = cnt_q - 5'd2;
        end
        if (cnt_q <= 5'd2) begin
          state_d = DONE;
        end
`else
        data_d = stepOne;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The result is exposed only while DONE so y_out moves solely on state changes.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.y_out     = (state_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_modular_double_seq.sv
// Self-checking bench for modular_double_seq: directed cases plus random ops vs an arithmetic model.
module tb_modular_double_seq;

  localparam longint unsigned QK = 3329;
  localparam longint unsigned QD = 8380417;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  modular_double_seq_if bus ();

  modular_double_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each lane is x mod q, scaled by 2^k with plain 64-bit arithmetic.
  function automatic logic [23:0] refResult(input logic [23:0] x, input int k, input logic mode);
    longint unsigned p;
    longint unsigned v;
    longint unsigned h;
    longint unsigned l;
    p = 64'd1 << k;
    if (mode) begin
      v = ((64'(x[22:0]) % QD) * p) % QD;
      return {1'b0, v[22:0]};
    end
    h = ((64'(x[23:12]) % QK) * p) % QK;
    l = ((64'(x[11:0]) % QK) * p) % QK;
    return {h[11:0], l[11:0]};
  endfunction

  function automatic int expLatency(input int k);
`ifdef MODULAR_DOUBLE_DUAL_STEP_EN
    return (k + 1) / 2 + 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one operation; while holding out_ready low for `hold` cycles it also tries a stray input.
  task automatic applyStimulus(input logic [23:0] x, input logic [4:0] k, input logic mode,
                               input int hold, output logic [23:0] y, output int cycles);
    @(negedge clk);
    bus.x_in     = x;
    bus.k_in     = k;
    bus.KD_mode  = mode;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x_in     = 24'($urandom);
    bus.k_in     = 5'($urandom);
    bus.KD_mode  = 1'($urandom);
    cycles = 1;
    checkOutput("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    checkOutput("in_ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
    while (bus.out_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    y = bus.y_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in     = 24'd5;
      bus.k_in     = 5'd3;
      @(posedge clk);
      #1;
      checkOutput("hold_y_stable", {8'd0, bus.y_out}, {8'd0, y});
      checkOutput("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("in_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("out_valid_after_handshake", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic runCase(input string tag, input logic [23:0] x, input logic [4:0] k,
                         input logic mode, input int hold, output logic [23:0] y);
    int cycles;
    applyStimulus(x, k, mode, hold, y, cycles);
    checkOutput({tag, "_y"}, {8'd0, y}, {8'd0, refResult(x, int'(k), mode)});
    checkOutput({tag, "_latency"}, cycles, expLatency(int'(k)));
  endtask

  initial begin
    logic [23:0] y;
    logic [23:0] x;
    logic [4:0]  k;
    logic        mode;
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.k_in      = '0;
    bus.KD_mode   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_y", {8'd0, bus.y_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runCase("ky_k1", {12'd1665, 12'd3328}, 5'd1, 1'b0, 0, y);
    checkOutput("ky_k1_const", {8'd0, y}, {8'd0, 12'd1, 12'd3327});
    runCase("dil_half_inv", 24'd4190209, 5'd1, 1'b1, 0, y);
    checkOutput("dil_half_inv_const", {8'd0, y}, 32'd1);
    runCase("dil_k23", 24'd1, 5'd23, 1'b1, 0, y);
    checkOutput("dil_k23_const", {8'd0, y}, 32'd8191);
    runCase("ky_k0_reduce", {12'd1, 12'd3329}, 5'd0, 1'b0, 0, y);
    checkOutput("ky_k0_reduce_const", {8'd0, y}, {8'd0, 12'd1, 12'd0});
    runCase("ky_k12_hold", {12'd1, 12'd1}, 5'd12, 1'b0, 5, y);
    checkOutput("ky_k12_hold_const", {8'd0, y}, {8'd0, 12'd767, 12'd767});
    checkOutput("stray_not_accepted", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a long Dilithium run.
    @(negedge clk);
    bus.x_in     = 24'd12345;
    bus.k_in     = 5'd20;
    bus.KD_mode  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("midrun_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrun_rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrun_rst_y", {8'd0, bus.y_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runCase("after_rst", 24'd2, 5'd1, 1'b1, 0, y);
    checkOutput("after_rst_const", {8'd0, y}, 32'd4);

    for (int n = 0; n < 24; n++) begin
      mode = 1'($urandom);
      k    = 5'($urandom_range(0, 31));
      if (mode) begin
        x = {1'b0, 23'($urandom_range(0, 8388607))};
      end else begin
        x = {12'($urandom_range(0, 6657)), 12'($urandom_range(0, 6657))};
      end
      runCase("random", x, k, mode, int'($urandom_range(0, 2)), y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
